// File: rtl/md5_chunk_engine_if.sv
// ---------------------------------------------------------------------------
// md5_chunk_engine_if
//   Bundles the control, message-load, constant-ROM and digest signals of
//   md5_chunk_engine. The engine connects through the slave modport; the
//   driver (controller, external K/S ROMs, message source) uses master.
//
//   start     : request to compress the loaded block (to engine)
//   chain     : 1 = continue from current digest, 0 = restart from IV
//   busy      : engine crunching or finalizing (from engine)
//   done      : one-cycle pulse when the digest is updated (from engine)
//   digest    : {d0,c0,b0,a0} (from engine)
//   iaddr     : round index for the external K/S ROMs (from engine)
//   kdata     : K[iaddr], combinational (to engine)
//   sdata     : S[iaddr], combinational (to engine)
//   msg_we    : message word write enable (to engine)
//   msg_waddr : message word index 0..15 (to engine)
//   msg_wdata : little-endian message word (to engine)
// ---------------------------------------------------------------------------
interface md5_chunk_engine_if;
    logic         start;
    logic         chain;
    logic         busy;
    logic         done;
    logic [127:0] digest;
    logic [5:0]   iaddr;
    logic [31:0]  kdata;
    logic [4:0]   sdata;
    logic         msg_we;
    logic [3:0]   msg_waddr;
    logic [31:0]  msg_wdata;

    modport master (
        output start, chain, kdata, sdata, msg_we, msg_waddr, msg_wdata,
        input  busy, done, digest, iaddr
    );

    modport slave (
        input  start, chain, kdata, sdata, msg_we, msg_waddr, msg_wdata,
        output busy, done, digest, iaddr
    );
endinterface

// File: rtl/md5_chunk_engine.sv
// ---------------------------------------------------------------------------
// md5_chunk_engine
//   MD5 compression core: one round per clock, 64 rounds plus one finalize
//   cycle per 512-bit chunk. The message block lives in a two-bank store so
//   the next chunk can be written while the current one is crunched. Chain
//   mode continues from the running digest instead of the IV. K/S constants
//   come from external ROMs addressed by the round index.
//
//   clk   : clock
//   reset : synchronous, active-high; aborts any chunk in flight
//   bus   : md5_chunk_engine_if.slave (control, message load, ROMs, digest)
// ---------------------------------------------------------------------------
module md5_chunk_engine #(
    parameter logic [31:0] INITA = 32'h67452301,
    parameter logic [31:0] INITB = 32'hefcdab89,
    parameter logic [31:0] INITC = 32'h98badcfe,
    parameter logic [31:0] INITD = 32'h10325476
) (
    input  logic              clk,
    input  logic              reset,
    md5_chunk_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CRUNCH,
        FINAL
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] a_q, b_q, c_q, d_q;
    logic [31:0] a_d, b_d, c_d, d_d;
    logic [31:0] a0_q, b0_q, c0_q, d0_q;
    logic [31:0] a0_d, b0_d, c0_d, d0_d;
    logic        load_bank_q, load_bank_d;
    logic        comp_bank_q, comp_bank_d;
    logic        done_q, done_d;

    // Message store: address = {bank, word}. Not reset.
    logic [31:0] msg_mem [32];

    logic [31:0] f_w;
    logic [3:0]  g_w;
    logic [31:0] t_w;
    logic [31:0] rot_w;

    // Writes always target the load bank; a write in the accept cycle uses
    // the pre-swap bank and therefore belongs to the chunk being started.
    always_ff @(posedge clk) begin
        if (bus.msg_we) begin
            msg_mem[{load_bank_q, bus.msg_waddr}] <= bus.msg_wdata;
        end
    end

    // Round datapath
    always_comb begin
        f_w = '0;
        g_w = '0;
        unique case (round_q[5:4])
            2'd0: begin
                f_w = (b_q & c_q) | (~b_q & d_q);
                g_w = round_q[3:0];
            end
            2'd1: begin
                f_w = (d_q & b_q) | (~d_q & c_q);
                g_w = (round_q[3:0] * 4'd5) + 4'd1;
            end
            2'd2: begin
                f_w = b_q ^ c_q ^ d_q;
                g_w = (round_q[3:0] * 4'd3) + 4'd5;
            end
            2'd3: begin
                f_w = c_q ^ (b_q | ~d_q);
                g_w = round_q[3:0] * 4'd7;
            end
        endcase
        t_w   = a_q + f_w + bus.kdata + msg_mem[{comp_bank_q, g_w}];
        // A shift by 32 yields zero, so sdata = 0 degenerates to identity.
        rot_w = (t_w << bus.sdata) | (t_w >> (6'd32 - {1'b0, bus.sdata}));
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        a0_d        = a0_q;
        b0_d        = b0_q;
        c0_d        = c0_q;
        d0_d        = d0_q;
        load_bank_d = load_bank_q;
        comp_bank_d = comp_bank_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    comp_bank_d = load_bank_q;
                    load_bank_d = ~load_bank_q;
                    round_d     = '0;
                    state_d     = CRUNCH;
                    if (bus.chain) begin
                        a_d = a0_q;
                        b_d = b0_q;
                        c_d = c0_q;
                        d_d = d0_q;
                    end else begin
                        a0_d = INITA;
                        b0_d = INITB;
                        c0_d = INITC;
                        d0_d = INITD;
                        a_d  = INITA;
                        b_d  = INITB;
                        c_d  = INITC;
                        d_d  = INITD;
                    end
                end
            end
            CRUNCH: begin
                a_d     = d_q;
                b_d     = b_q + rot_w;
                c_d     = b_q;
                d_d     = c_q;
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                a0_d    = a0_q + a_q;
                b0_d    = b0_q + b_q;
                c0_d    = c0_q + c_q;
                d0_d    = d0_q + d_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            a_q         <= INITA;
            b_q         <= INITB;
            c_q         <= INITC;
            d_q         <= INITD;
            a0_q        <= INITA;
            b0_q        <= INITB;
            c0_q        <= INITC;
            d0_q        <= INITD;
            load_bank_q <= 1'b0;
            comp_bank_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            c0_q        <= c0_d;
            d0_q        <= d0_d;
            load_bank_q <= load_bank_d;
            comp_bank_q <= comp_bank_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.digest = {d0_q, c0_q, b0_q, a0_q};
    assign bus.iaddr  = round_q;

endmodule

// File: tb/tb_md5_chunk_engine.sv
// ---------------------------------------------------------------------------
// tb_md5_chunk_engine
//   Self-checking bench for md5_chunk_engine. Provides the K/S ROMs, loads
//   message blocks, and compares digests and cycle timing against a plain
//   MD5 block-compression function and published digest values.
// ---------------------------------------------------------------------------
module tb_md5_chunk_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md5_chunk_engine_if bus_if ();

    md5_chunk_engine #(
        .INITA(32'h67452301),
        .INITB(32'hefcdab89),
        .INITC(32'h98badcfe),
        .INITD(32'h10325476)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    localparam logic [127:0] INIT  = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] EMPTY = 128'h7e42f8ec980980e904b2008fd98c1dd4;
    localparam logic [127:0] ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
    localparam logic [127:0] A64   = {32'h67733f79, 32'h63034a5a, 32'h4971b580, 32'hd4424801};

    localparam logic [31:0] K_ROM [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Shift amounts: four per round group, repeating within the group.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    always_comb begin
        bus_if.kdata = K_ROM[bus_if.iaddr];
        bus_if.sdata = S_TAB[{bus_if.iaddr[5:4], bus_if.iaddr[1:0]}];
    end

    int checks   = 0;
    int failures = 0;
    logic [127:0] ref_dg;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned s);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [127:0] md5_ref(input logic [127:0] iv, input logic [31:0] m [16]);
        logic [31:0] a, b, c, d, f, tmp;
        int unsigned g;
        a = iv[31:0];
        b = iv[63:32];
        c = iv[95:64];
        d = iv[127:96];
        for (int unsigned i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            tmp = d;
            d   = c;
            c   = b;
            b   = b + rotl32(a + f + K_ROM[i] + m[g], S_TAB[(i / 16) * 4 + i % 4]);
            a   = tmp;
        end
        return {d + iv[127:96], c + iv[95:64], b + iv[63:32], a + iv[31:0]};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_block(input logic [31:0] m [16]);
        for (int unsigned i = 0; i < 16; i++) begin
            bus_if.msg_we    = 1'b1;
            bus_if.msg_waddr = 4'(i);
            bus_if.msg_wdata = m[i];
            tick();
        end
        bus_if.msg_we = 1'b0;
    endtask

    task automatic launch(input logic ch);
        bus_if.start = 1'b1;
        bus_if.chain = ch;
        tick();
        bus_if.start = 1'b0;
        bus_if.chain = 1'($urandom);
    endtask

    // Returns in the cycle where done is seen (n counted from the accept edge).
    // mode 1: write nxt into the load bank during the crunch; mode 2: random
    // writes into the load bank. pulses: spurious start at n=10 and n=65.
    task automatic wait_done(input int unsigned mode, input logic [31:0] nxt [16], input bit pulses,
                             output int n_done, output int n_busy, output logic busy_at_done,
                             output logic [127:0] dg, output logic [127:0] first_dg,
                             output logic [127:0] mid_dg);
        n_done       = -1;
        n_busy       = 0;
        busy_at_done = 1'b1;
        dg           = '0;
        mid_dg       = '0;
        first_dg     = bus_if.digest;
        for (int n = 1; n <= 150; n++) begin
            if (n == 30) mid_dg = bus_if.digest;
            if (bus_if.done === 1'b1) begin
                n_done       = n;
                busy_at_done = bus_if.busy;
                dg           = bus_if.digest;
                break;
            end
            if (bus_if.busy === 1'b1) n_busy++;
            bus_if.start = pulses && (n == 10 || n == 65);
            bus_if.chain = 1'b0;
            if (mode == 1 && n >= 2 && n <= 17) begin
                bus_if.msg_we    = 1'b1;
                bus_if.msg_waddr = 4'(n - 2);
                bus_if.msg_wdata = nxt[n - 2];
            end else if (mode == 2 && n < 60) begin
                bus_if.msg_we    = 1'($urandom);
                bus_if.msg_waddr = 4'($urandom);
                bus_if.msg_wdata = $urandom;
            end else begin
                bus_if.msg_we = 1'b0;
            end
            tick();
        end
        bus_if.start  = 1'b0;
        bus_if.msg_we = 1'b0;
    endtask

    function automatic void set_empty(output logic [31:0] m [16]);
        for (int unsigned i = 0; i < 16; i++) m[i] = '0;
        m[0] = 32'h00000080;
    endfunction

    function automatic void set_abc(output logic [31:0] m [16]);
        for (int unsigned i = 0; i < 16; i++) m[i] = '0;
        m[0]  = 32'h80636261;
        m[14] = 32'h00000018;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.iaddr !== 6'd0) begin failures++; $display("FAIL reset_iaddr got=%0d exp=0", bus_if.iaddr); end
        checks++; if (bus_if.digest !== INIT) begin failures++; $display("FAIL reset_digest got=%h exp=%h", bus_if.digest, INIT); end
        ref_dg = INIT;
    endtask

    task automatic test_empty();
        logic [31:0] m [16];
        logic [127:0] dg, f_dg, m_dg;
        int nd, nb;
        logic bd;
        set_empty(m);
        write_block(m);
        launch(1'b0);
        wait_done(0, m, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = md5_ref(INIT, m);
        checks++; if (nd !== 66) begin failures++; $display("FAIL empty_latency got=%0d exp=66", nd); end
        checks++; if (nb !== 65) begin failures++; $display("FAIL empty_busy_cycles got=%0d exp=65", nb); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL empty_busy_at_done got=%b exp=0", bd); end
        checks++; if (dg !== EMPTY) begin failures++; $display("FAIL empty_digest got=%h exp=%h", dg, EMPTY); end
        checks++; if (dg !== ref_dg) begin failures++; $display("FAIL empty_model got=%h exp=%h", dg, ref_dg); end
        tick();
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.digest !== EMPTY) begin failures++; $display("FAIL digest_hold got=%h exp=%h", bus_if.digest, EMPTY); end
    endtask

    task automatic test_abc();
        logic [31:0] m [16];
        logic [127:0] dg, f_dg, m_dg;
        int nd, nb;
        logic bd;
        set_abc(m);
        write_block(m);
        launch(1'b0);
        wait_done(0, m, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = md5_ref(INIT, m);
        checks++; if (f_dg !== INIT) begin failures++; $display("FAIL abc_start_shows_init got=%h exp=%h", f_dg, INIT); end
        checks++; if (nd !== 66) begin failures++; $display("FAIL abc_latency got=%0d exp=66", nd); end
        checks++; if (dg !== ABC) begin failures++; $display("FAIL abc_digest got=%h exp=%h", dg, ABC); end
        checks++; if (dg !== ref_dg) begin failures++; $display("FAIL abc_model got=%h exp=%h", dg, ref_dg); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] m_e [16];
        logic [31:0] m_a [16];
        logic [127:0] dg, f_dg, m_dg;
        int nd, nb;
        logic bd;
        set_empty(m_e);
        set_abc(m_a);
        write_block(m_e);
        launch(1'b0);
        wait_done(1, m_a, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        checks++; if (dg !== EMPTY) begin failures++; $display("FAIL b2b_first_digest got=%h exp=%h", dg, EMPTY); end
        launch(1'b0);
        wait_done(0, m_a, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = ABC;
        checks++; if (nd !== 66) begin failures++; $display("FAIL b2b_spacing got=%0d exp=66", nd); end
        checks++; if (dg !== ABC) begin failures++; $display("FAIL b2b_second_digest got=%h exp=%h", dg, ABC); end
        tick();
    endtask

    task automatic test_chain();
        logic [31:0] m1 [16];
        logic [31:0] m2 [16];
        logic [127:0] dg, f_dg, m_dg, mid;
        int nd, nb;
        logic bd;
        for (int unsigned i = 0; i < 16; i++) begin
            m1[i] = 32'h61616161;
            m2[i] = '0;
        end
        m2[0]  = 32'h00000080;
        m2[14] = 32'h00000200;
        write_block(m1);
        launch(1'b0);
        wait_done(0, m1, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        mid = md5_ref(INIT, m1);
        checks++; if (dg !== mid) begin failures++; $display("FAIL chain_first got=%h exp=%h", dg, mid); end
        tick();
        write_block(m2);
        launch(1'b1);
        wait_done(0, m2, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = md5_ref(mid, m2);
        checks++; if (f_dg !== mid) begin failures++; $display("FAIL chain_start_keeps got=%h exp=%h", f_dg, mid); end
        checks++; if (dg !== A64) begin failures++; $display("FAIL chain_digest got=%h exp=%h", dg, A64); end
        checks++; if (dg !== ref_dg) begin failures++; $display("FAIL chain_model got=%h exp=%h", dg, ref_dg); end
        tick();
    endtask

    task automatic test_ignored_start();
        logic [31:0] m [16];
        logic [127:0] dg, f_dg, m_dg, prev;
        int nd, nb, extra;
        logic bd;
        for (int unsigned i = 0; i < 16; i++) m[i] = $urandom;
        prev = ref_dg;
        write_block(m);
        launch(1'b1);
        wait_done(0, m, 1'b1, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = md5_ref(prev, m);
        checks++; if (m_dg !== prev) begin failures++; $display("FAIL ign_mid_digest got=%h exp=%h", m_dg, prev); end
        checks++; if (nd !== 66) begin failures++; $display("FAIL ign_latency got=%0d exp=66", nd); end
        checks++; if (dg !== ref_dg) begin failures++; $display("FAIL ign_digest got=%h exp=%h", dg, ref_dg); end
        extra = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ign_no_restart got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] m [16];
        logic [127:0] dg, f_dg, m_dg;
        int nd, nb, seen;
        logic bd;
        set_empty(m);
        write_block(m);
        launch(1'b0);
        for (int n = 1; n < 30; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_dg = INIT;
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.digest !== INIT) begin failures++; $display("FAIL rstmid_digest got=%h exp=%h", bus_if.digest, INIT); end
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (bus_if.done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        write_block(m);
        launch(1'b0);
        wait_done(0, m, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
        ref_dg = EMPTY;
        checks++; if (dg !== EMPTY) begin failures++; $display("FAIL rstmid_recover got=%h exp=%h", dg, EMPTY); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] m [16];
        logic [127:0] dg, f_dg, m_dg, exp_dg;
        int nd, nb;
        logic bd, ch;
        for (int unsigned it = 0; it < 8; it++) begin
            for (int unsigned i = 0; i < 16; i++) m[i] = $urandom;
            ch = (it == 0) ? 1'b0 : 1'($urandom);
            write_block(m);
            launch(ch);
            wait_done(2, m, 1'b0, nd, nb, bd, dg, f_dg, m_dg);
            exp_dg = md5_ref(ch ? ref_dg : INIT, m);
            ref_dg = exp_dg;
            checks++; if (nd !== 66) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=66", it, nd); end
            checks++; if (dg !== exp_dg) begin failures++; $display("FAIL rand%0d_digest chain=%b got=%h exp=%h", it, ch, dg, exp_dg); end
            tick();
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.chain     = 1'b0;
        bus_if.msg_we    = 1'b0;
        bus_if.msg_waddr = '0;
        bus_if.msg_wdata = '0;
        ref_dg           = INIT;
        test_reset();
        test_empty();
        test_abc();
        test_back_to_back();
        test_chain();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
